// File: rtl/serial_tx.sv
// Byte-wide serial transmitter: start bit, 8 data bits LSB first, optional
// parity bit, stop bit, one clk per bit. Back-to-back frames need no idle gap.
module serial_tx #(
  parameter int PARITY = 1  // 0 = none, 1 = even, 2 = odd
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       out,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic HAS_PAR = (PARITY != 0);
  localparam logic ODD     = (PARITY == 2);

  state_t     state, state_d;
  logic [7:0] sr, sr_d;
  logic [2:0] idx, idx_d;
  logic       par, par_d;
  logic       out_d;
  logic       accept;

  assign ready  = (state == S_IDLE) || (state == S_STOP);
  assign busy   = (state == S_START) || (state == S_DATA) ||
                  (state == S_PARITY) || (state == S_STOP);
  assign accept = valid && ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      sr    <= '0;
      idx   <= '0;
      par   <= 1'b0;
      out   <= 1'b1;
    end else begin
      state <= state_d;
      sr    <= sr_d;
      idx   <= idx_d;
      par   <= par_d;
      out   <= out_d;
    end
  end

  // out is registered, so each branch computes the bit shown in the *next* state.
  always_comb begin
    state_d = state;
    sr_d    = sr;
    idx_d   = idx;
    par_d   = par;
    out_d   = 1'b1;
    case (state)
      S_IDLE, S_STOP: begin
        if (accept) begin
          state_d = S_START;
          out_d   = 1'b0;
          sr_d    = data;
          par_d   = (^data) ^ ODD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        state_d = S_DATA;
        out_d   = sr[0];
        sr_d    = sr >> 1;
      end
      S_DATA: begin
        if (idx == 3'd7) begin
          idx_d = 3'd0;
          if (HAS_PAR) begin
            state_d = S_PARITY;
            out_d   = par;
          end else begin
            state_d = S_STOP;
          end
        end else begin
          idx_d = idx + 3'd1;
          out_d = sr[0];
          sr_d  = sr >> 1;
        end
      end
      S_PARITY: state_d = S_STOP;
      default: begin
        state_d = S_IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: one instance per parity mode, table of frames
// plus hand sequences for back-to-back, mid-frame reset and data churn.
module tb_serial_tx;

  logic       clk;
  logic       reset;
  logic [7:0] d   [3];
  logic       v   [3];
  logic       rdy [3];
  logic       o   [3];
  logic       bsy [3];

  int n_checks = 0;
  int n_fail   = 0;

  serial_tx #(.PARITY(0)) dut0 (.clk(clk), .reset(reset), .data(d[0]), .valid(v[0]),
                                .ready(rdy[0]), .out(o[0]), .busy(bsy[0]));
  serial_tx #(.PARITY(1)) dut1 (.clk(clk), .reset(reset), .data(d[1]), .valid(v[1]),
                                .ready(rdy[1]), .out(o[1]), .busy(bsy[1]));
  serial_tx #(.PARITY(2)) dut2 (.clk(clk), .reset(reset), .data(d[2]), .valid(v[2]),
                                .ready(rdy[2]), .out(o[2]), .busy(bsy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         sel;   // instance index == PARITY mode
    logic [7:0] b;
    string      s;     // expected line bits in transmit order
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start(input int sel, input logic [7:0] b);
    @(negedge clk);
    d[sel] = b;
    v[sel] = 1'b1;
    @(posedge clk);
  endtask

  task automatic send(input int sel, input logic [7:0] b, input string s);
    start(sel, b);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      if (i == 0) v[sel] = 1'b0;
      chk($sformatf("frame_p%0d_%02h_bit%0d", sel, b, i), o[sel], s[i] == "1");
      chk("frame_busy", bsy[sel], 1'b1);
      chk("frame_ready", rdy[sel], i == s.len() - 1);
    end
    @(negedge clk);
    chk("post_out", o[sel], 1'b1);
    chk("post_busy", bsy[sel], 1'b0);
    chk("post_ready", rdy[sel], 1'b1);
  endtask

  initial begin
    string s2;
    tbl[0] = '{1, 8'hA5, "01010010101"};
    tbl[1] = '{2, 8'h01, "01000000001"};
    tbl[2] = '{1, 8'h01, "01000000011"};
    tbl[3] = '{0, 8'h00, "0000000001"};
    tbl[4] = '{0, 8'hFF, "0111111111"};
    tbl[5] = '{2, 8'h00, "00000000011"};
    tbl[6] = '{1, 8'h3C, "00011110001"};
    tbl[7] = '{2, 8'h80, "00000000101"};
    tbl[8] = '{0, 8'h5A, "0010110101"};

    for (int k = 0; k < 3; k++) begin
      d[k] = 8'h00;
      v[k] = 1'b0;
    end
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_out", o[k], 1'b1);
      chk("reset_busy", bsy[k], 1'b0);
      chk("reset_ready", rdy[k], 1'b1);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // idle line with valid low
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_out", o[1], 1'b1);
      chk("idle_ready", rdy[1], 1'b1);
      chk("idle_busy", bsy[1], 1'b0);
    end

    for (int t = 0; t < 9; t++) send(tbl[t].sel, tbl[t].b, tbl[t].s);

    // back-to-back, no parity, valid held high across the STOP accept
    s2 = {"0000000001", "0111111111"};
    start(0, 8'h00);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) d[0] = 8'hFF;
      if (i == 10) v[0] = 1'b0;
      chk($sformatf("b2b_bit%0d", i), o[0], s2[i] == "1");
      chk("b2b_busy", bsy[0], 1'b1);
    end
    @(negedge clk);
    chk("b2b_end_out", o[0], 1'b1);
    chk("b2b_end_busy", bsy[0], 1'b0);

    // reset during DATA bit 3 of F0, with a concurrent accept attempt
    start(1, 8'hF0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) v[1] = 1'b0;
      chk($sformatf("abort_bit%0d", i), o[1], 1'b0);
    end
    reset = 1'b1;
    #1;
    chk("abort_out", o[1], 1'b1);
    chk("abort_busy", bsy[1], 1'b0);
    chk("abort_ready", rdy[1], 1'b1);
    d[1] = 8'h3C;
    v[1] = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_prio_out", o[1], 1'b1);
    chk("rst_prio_busy", bsy[1], 1'b0);
    @(negedge clk);
    reset = 1'b0;
    v[1] = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", bsy[1], 1'b0);
    send(1, 8'h3C, "00011110001");

    // data churn while busy; next byte only taken at STOP
    s2 = {"01010010101", "00011110001"};
    start(1, 8'hA5);
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (i == 10) d[1] = 8'h3C;
      else d[1] = 8'($urandom);
      if (i == 11) v[1] = 1'b0;
      chk($sformatf("churn_bit%0d", i), o[1], s2[i] == "1");
      chk("churn_ready", rdy[1], (i == 10) || (i == 21));
    end
    @(negedge clk);
    chk("churn_end_out", o[1], 1'b1);
    chk("churn_end_busy", bsy[1], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter PARITY, default 1, selects the parity bit: 0 = none, 1 = even, 2 = odd.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 data  input  8  parallel byte to transmit; sampled only on an accept edge.
REQ-005 valid  input  1  high when data holds a byte to send.
REQ-006 ready  output  1  high when the block can accept a byte this cycle.
REQ-007 out  output  1  serial line; idles high (1).
REQ-008 busy  output  1  high while a frame occupies the line (START through STOP).

Function
REQ-009 Frame format SHALL be: start bit 0; data[0]..data[7], LSB first; optional parity bit; stop bit 1. Each bit lasts exactly one clk cycle.
REQ-010 Frame length SHALL be 11 cycles when PARITY!=0 and 10 cycles when PARITY==0.
REQ-011 The state machine SHALL have the states IDLE, START, DATA, PARITY and STOP, with these transitions:
- IDLE->START on accept;
- START->DATA;
- DATA->DATA while the bit index is below 7;
- DATA->PARITY at index 7 when PARITY!=0;
- DATA->STOP at index 7 when PARITY==0;
- PARITY->STOP;
- STOP->START on accept, otherwise STOP->IDLE.
REQ-012 Accept SHALL occur on a rising edge where valid==1 and ready==1; data is latched into an internal shift register on that edge.
REQ-013 ready SHALL be 1 in IDLE and STOP and 0 in all other states; it is combinational from state only and never depends on valid.
REQ-014 out SHALL be registered. On the accept edge out <= 0, so the start bit appears in the cycle immediately after acceptance (latency 1 edge).
REQ-015 In DATA the shift register SHALL shift right one bit per cycle, with out driven from bit 0; the 3-bit index counter wraps from 7 to 0 on leaving DATA.
REQ-016 Even parity SHALL equal the XOR of the 8 latched bits. Odd parity SHALL equal the inverse of that XOR. Parity is computed from the latched copy, not the live data input.
REQ-017 out SHALL be 1 in STOP and in IDLE.
REQ-018 Back-to-back accept in STOP SHALL start the next frame with no idle cycle, giving a period of exactly 10 or 11 cycles per byte.
REQ-019 busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-020 Changes to data or valid while ready==0 SHALL have no effect on the frame in progress.
REQ-021 With valid held low, the block SHALL remain in IDLE with out==1 indefinitely.
REQ-022 Illegal or unused state encodings SHALL return to IDLE on the next edge.

Reset
REQ-023 While reset==1, the block SHALL immediately, without waiting for clk, force: state=IDLE, out=1, busy=0, ready=1, shift register=0, bit index=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame; no remaining bits are sent.
REQ-025 After reset deasserts, the first accept SHALL begin a complete new frame.
REQ-026 Reset SHALL take priority over any simultaneous accept.

Verification
REQ-027 PARITY=1, send 8'hA5 -> out sequence 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles; then out==1 and ready==1.
REQ-028 PARITY=2, send 8'h01 -> out sequence 0,1,0,0,0,0,0,0,0,0,1 (parity 0); with PARITY=1 the same byte gives parity bit 1.
REQ-029 PARITY=0, send 8'h00 then 8'hFF back-to-back with valid held high -> out sequence 0,0,0,0,0,0,0,0,0,1 then 0,1,1,1,1,1,1,1,1,1; exactly 20 cycles; busy stays high throughout.
REQ-030 Assert reset at DATA bit 3 of an 8'hF0 frame -> out==1 and busy==0 before the next clk edge; the next accepted 8'h3C is sent as a complete, correct frame.
REQ-031 Hold valid=0 for 50 cycles after reset -> out==1, ready==1, busy==0 throughout.
REQ-032 Change data every cycle during a frame with valid=1 -> transmitted bits match the byte latched at accept; the next byte is accepted only in STOP.
